// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   - state_e      : loader FSM states
//   - ERR_*        : values reported on err_code
//   - *_DEF        : default geometry, frame header byte and idle limit
package prog_loader_pkg;

    localparam int         DEPTH_DEF   = 32;
    localparam int         AW_DEF      = 5;
    localparam logic [7:0] SYNC_DEF    = 8'hA5;
    localparam int         TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        ADDR,
        DATA,
        CSUM,
        RESP
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input, instruction-memory write port and status of the loader.
//   master : stream source / consumer of status (drives in_valid, in_data)
//   slave  : the loader (drives in_ready, mem_*, busy, done, err_code)
interface prog_loader_if #(
    parameter int AW = 5
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          busy;
    logic          done;
    logic [1:0]    err_code;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_data, busy, done, err_code
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_data, busy, done, err_code
    );
endinterface

// File: rtl/prog_loader.sv
// Loads framed byte streams into the accumulator core's instruction memory.
// Frame: SYNC, LEN, ADDR, LEN data bytes, CSUM (XOR of LEN, ADDR and data).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : prog_loader_if.slave
//              in_valid/in_data/in_ready  byte stream handshake
//              mem_we/mem_addr/mem_data   memory write port (1-cycle latency)
//              busy                       frame in progress, core holds
//              done                       1-cycle pulse at end of each frame
//              err_code                   0 ok, 1 length, 2 checksum, 3 timeout
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         DEPTH   = DEPTH_DEF,
    parameter int         AW      = AW_DEF,
    parameter logic [7:0] SYNC    = SYNC_DEF,
    parameter int         TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus
);

    localparam int              CW       = $clog2(DEPTH + 1);
    localparam int              TW       = $clog2(TIMEOUT + 1);
    localparam logic [8:0]      DEPTH_B  = 9'(DEPTH);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    csum_q;
    logic [TW-1:0] tmo_q;
    logic [1:0]    err_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [7:0]    mem_data_q;

    logic in_ready, busy, done;
    logic accept, framed, tmo_hit, is_sync, len_bad, last_data, csum_ok;

    assign accept    = bus.in_valid && in_ready;
    assign framed    = (state_q == LEN) || (state_q == ADDR) ||
                       (state_q == DATA) || (state_q == CSUM);
    // Counter holds the idle cycles seen so far; this idle cycle is the
    // TIMEOUT-th one when the count already stands at TIMEOUT-1.
    assign tmo_hit   = framed && !accept && (tmo_q == TMO_LAST);
    assign is_sync   = (bus.in_data == SYNC);
    assign len_bad   = (bus.in_data == 8'd0) || ({1'b0, bus.in_data} > DEPTH_B);
    assign last_data = (cnt_q == CW'(1));
    assign csum_ok   = (bus.in_data == csum_q);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept && is_sync) state_d = LEN;
            LEN: begin
                if (accept)       state_d = len_bad ? RESP : ADDR;
                else if (tmo_hit) state_d = RESP;
            end
            ADDR: begin
                if (accept)       state_d = DATA;
                else if (tmo_hit) state_d = RESP;
            end
            DATA: begin
                if (accept)       state_d = last_data ? CSUM : DATA;
                else if (tmo_hit) state_d = RESP;
            end
            CSUM: if (accept || tmo_hit) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- state-decoded outputs ----------------
    always_comb begin
        in_ready = 1'b1;
        busy     = 1'b0;
        done     = 1'b0;
        if (state_q != IDLE) busy = 1'b1;
        if (state_q == RESP) begin
            in_ready = 1'b0;
            done     = 1'b1;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            cnt_q      <= '0;
            csum_q     <= '0;
            tmo_q      <= '0;
            err_q      <= ERR_NONE;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            mem_we_q <= 1'b0;

            // Idle counter only runs inside a frame and restarts on every byte.
            if (framed && !accept) tmo_q <= tmo_q + 1'b1;
            else                   tmo_q <= '0;

            if (tmo_hit) err_q <= ERR_TIMEOUT;

            if (accept) begin
                unique case (state_q)
                    IDLE: if (is_sync) begin
                        csum_q <= '0;
                        err_q  <= ERR_NONE;
                    end
                    LEN: begin
                        csum_q <= csum_q ^ bus.in_data;
                        cnt_q  <= bus.in_data[CW-1:0];
                        if (len_bad) err_q <= ERR_LEN;
                    end
                    ADDR: begin
                        csum_q <= csum_q ^ bus.in_data;
                        ptr_q  <= bus.in_data[AW-1:0];
                    end
                    DATA: begin
                        csum_q     <= csum_q ^ bus.in_data;
                        cnt_q      <= cnt_q - 1'b1;
                        ptr_q      <= ptr_q + 1'b1;   // wraps modulo DEPTH
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= ptr_q;
                        mem_data_q <= bus.in_data;
                    end
                    CSUM: if (!csum_ok) err_q <= ERR_CSUM;
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.err_code = err_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: normal, wrap, bad checksum, bad length,
// timeout with leading garbage, and reset in the middle of a frame.
module tb_prog_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   wr_cnt  = 0;
    int   wr0;

    always #5 clk = ~clk;

    prog_loader_if #(.AW(5)) bus ();

    prog_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) if (bus.mem_we) wr_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One byte, accepted at the next edge (loader is ready outside RESP).
    task automatic send(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Data byte: the write must appear right after its accepting edge.
    task automatic send_wr(input string tag, input logic [7:0] b, input logic [4:0] a);
        send(b);
        chk({tag, "_we"},   32'(bus.mem_we),   32'd1);
        chk({tag, "_addr"}, 32'(bus.mem_addr), 32'(a));
        chk({tag, "_data"}, 32'(bus.mem_data), 32'(b));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        idle(2);
        rst = 1'b0;

        // reset state
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_we",    32'(bus.mem_we),   32'd0);
        chk("rst_addr",  32'(bus.mem_addr), 32'd0);
        chk("rst_data",  32'(bus.mem_data), 32'd0);
        chk("rst_busy",  32'(bus.busy),     32'd0);
        chk("rst_done",  32'(bus.done),     32'd0);
        chk("rst_err",   32'(bus.err_code), 32'd0);

        // normal frame
        wr0 = wr_cnt;
        send(8'hA5);
        chk("nrm_busy", 32'(bus.busy), 32'd1);
        send(8'h03);
        send(8'h04);
        send_wr("nrm0", 8'h01, 5'd4);
        send_wr("nrm1", 8'h10, 5'd5);
        send_wr("nrm2", 8'h0A, 5'd6);
        send(8'h1C);
        chk("nrm_done",  32'(bus.done),     32'd1);
        chk("nrm_err",   32'(bus.err_code), 32'd0);
        chk("nrm_rdy0",  32'(bus.in_ready), 32'd0);
        chk("nrm_busyR", 32'(bus.busy),     32'd1);
        idle(1);
        chk("nrm_done0", 32'(bus.done),     32'd0);
        chk("nrm_idle",  32'(bus.busy),     32'd0);
        chk("nrm_rdy1",  32'(bus.in_ready), 32'd1);
        chk("nrm_wrs",   32'(wr_cnt - wr0), 32'd3);

        // wrap-around
        wr0 = wr_cnt;
        send(8'hA5);
        send(8'h02);
        send(8'h1F);
        send_wr("wrp0", 8'h11, 5'd31);
        send_wr("wrp1", 8'h22, 5'd0);
        send(8'h2E);
        chk("wrp_done", 32'(bus.done),     32'd1);
        chk("wrp_err",  32'(bus.err_code), 32'd0);
        idle(1);
        chk("wrp_wrs",  32'(wr_cnt - wr0), 32'd2);

        // bad checksum: writes stay, err sticks until next SYNC
        wr0 = wr_cnt;
        send(8'hA5);
        send(8'h03);
        send(8'h04);
        send_wr("bcs0", 8'h01, 5'd4);
        send_wr("bcs1", 8'h10, 5'd5);
        send_wr("bcs2", 8'h0A, 5'd6);
        send(8'h1D);
        chk("bcs_done", 32'(bus.done),     32'd1);
        chk("bcs_err",  32'(bus.err_code), 32'd2);
        idle(1);
        send(8'h07);
        idle(3);
        chk("bcs_hold", 32'(bus.err_code), 32'd2);
        chk("bcs_idle", 32'(bus.busy),     32'd0);
        chk("bcs_wrs",  32'(wr_cnt - wr0), 32'd3);
        send(8'hA5);
        chk("bcs_clr",  32'(bus.err_code), 32'd0);

        // bad length 0 (continues the frame just opened), then 01 discarded
        wr0 = wr_cnt;
        send(8'h00);
        chk("bl0_done", 32'(bus.done),     32'd1);
        chk("bl0_err",  32'(bus.err_code), 32'd1);
        idle(1);
        send(8'h01);
        chk("bl0_disc", 32'(bus.busy),     32'd0);
        chk("bl0_hold", 32'(bus.err_code), 32'd1);
        // bad length 33
        send(8'hA5);
        send(8'h21);
        chk("bl33_done", 32'(bus.done),     32'd1);
        chk("bl33_err",  32'(bus.err_code), 32'd1);
        idle(2);
        chk("bl_wrs",    32'(wr_cnt - wr0), 32'd0);

        // timeout with leading garbage
        wr0 = wr_cnt;
        send(8'h00);
        send(8'hFF);
        chk("tmo_garb", 32'(bus.busy), 32'd0);
        send(8'hA5);
        send(8'h03);
        send(8'h04);
        send_wr("tmo0", 8'h01, 5'd4);
        idle(254);
        chk("tmo_early", 32'(bus.done),     32'd0);
        idle(1);
        chk("tmo_done",  32'(bus.done),     32'd1);
        chk("tmo_err",   32'(bus.err_code), 32'd3);
        idle(1);
        chk("tmo_idle",  32'(bus.busy),     32'd0);
        idle(5);
        chk("tmo_wrs",   32'(wr_cnt - wr0), 32'd1);

        // reset in the middle of DATA
        send(8'hA5);
        send(8'h03);
        send(8'h04);
        send_wr("mrs0", 8'h01, 5'd4);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h10;
        idle(1);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk("mrs_we",   32'(bus.mem_we),   32'd0);
        chk("mrs_busy", 32'(bus.busy),     32'd0);
        chk("mrs_err",  32'(bus.err_code), 32'd0);
        chk("mrs_done", 32'(bus.done),     32'd0);

        // clean frame after reset
        wr0 = wr_cnt;
        send(8'hA5);
        send(8'h03);
        send(8'h04);
        send_wr("aft0", 8'h01, 5'd4);
        send_wr("aft1", 8'h10, 5'd5);
        send_wr("aft2", 8'h0A, 5'd6);
        send(8'h1C);
        chk("aft_done", 32'(bus.done),     32'd1);
        chk("aft_err",  32'(bus.err_code), 32'd0);
        idle(1);
        chk("aft_wrs",  32'(wr_cnt - wr0), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream stage of the 8-bit accumulator core. Receives a framed byte stream over a valid/ready handshake and writes it into the core's 32-entry instruction memory through that memory's write port (we, 5-bit addr, 8-bit data).
- Asserts busy while loading so the core holds off execution.
- Validates each frame (length, XOR checksum, inter-byte timeout) and reports status per frame.

Parameters:
- DEPTH, 32, instruction memory entries.
- AW, 5, address width, equal to clog2(DEPTH).
- SYNC, 8'hA5, frame header byte.
- TIMEOUT, 255, maximum idle cycles between bytes inside a frame.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte.
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  AW  write address.
- mem_data  out  8  write data.
- busy  out  1  frame in progress; core must hold.
- done  out  1  one-cycle pulse at end of frame, pass or fail.
- err_code  out  2  0=ok, 1=bad length, 2=checksum, 3=timeout.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; in_ready=1; mem_we=0; mem_addr=0; mem_data=0; busy=0; done=0; err_code=0; timeout counter and checksum accumulator cleared. Reset takes priority over everything, including mid-frame. Memory writes already issued are not undone.
- Accept: a byte is accepted when in_valid && in_ready.
- Frame format: SYNC, LEN, ADDR, LEN data bytes, CSUM. CSUM = XOR of LEN, ADDR and every data byte.
- IDLE:
  - in_ready=1.
  - Accepted bytes other than SYNC are discarded.
  - SYNC -> LEN. Also clears err_code, clears the checksum accumulator and sets busy.
- LEN:
  - Accept the length byte and fold it into the checksum.
  - LEN=0 or LEN>DEPTH -> RESP with err_code=1.
  - Otherwise store the remaining count -> ADDR.
- ADDR: accept the byte; its low AW bits become the write pointer; fold into checksum -> DATA.
- DATA:
  - Each accepted byte registers mem_we=1, mem_addr=pointer, mem_data=byte on the next cycle (write latency 1).
  - Pointer increments modulo DEPTH (31 wraps to 0).
  - Byte is folded into checksum and the count decrements.
  - After the last byte -> CSUM.
- CSUM: accept the byte; mismatch -> err_code=2; -> RESP.
- RESP:
  - Lasts exactly one cycle with in_ready=0 and done=1.
  - Then IDLE with busy=0.
  - err_code holds until the next SYNC is accepted.
- mem_we is 1 only in the cycle after a DATA accept; otherwise 0.
- Checksum failure does not roll back writes already made. The core must not run when err_code!=0.
- Timeout:
  - In LEN, ADDR, DATA and CSUM, a counter increments on every cycle without an accept and clears on every accept.
  - When it reaches TIMEOUT -> RESP with err_code=3. No further writes occur.
- SYNC byte inside a frame is ordinary data (no resync).
- busy=1 from the cycle after SYNC is accepted through the RESP cycle.
- in_valid may drop at any time without penalty other than the timeout.

Decomposition:
- Package prog_loader_pkg holds: state enum (IDLE, LEN, ADDR, DATA, CSUM, RESP), err_code constants (ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT), SYNC default.
- Single module. No sub-module needed. The timeout counter and checksum accumulator are inline registers.

Test Plan:
- Normal frame: stream A5 03 04 01 10 0A 1C, in_valid held high -> writes mem[4]=01, mem[5]=10, mem[6]=0A, each one cycle after its accept; done pulse; err_code=0; busy low after RESP.
- Wrap-around: A5 02 1F 11 22 2E -> mem[31]=11 then mem[0]=22; err_code=0.
- Bad checksum: A5 03 04 01 10 0A 1D -> three writes still occur; done pulse with err_code=2; err_code stays 2 until the next A5 is accepted.
- Bad length: A5 00 then 01 -> err_code=1 with no mem_we. The following 01 is discarded in IDLE. Repeat with LEN=21 (33) -> err_code=1.
- Timeout and garbage: 00 FF A5 03 04 01, then in_valid=0 for 255 cycles -> leading 00 FF ignored; one write mem[4]=01; done with err_code=3 at the 255th idle cycle; no further writes.
- Reset mid-frame: assert rst for one cycle during DATA -> next cycle mem_we=0, busy=0, err_code=0. A following clean frame loads correctly.
